// File: rtl/llc_mem_if.sv
// LLC-to-memory request/response channel between the LLC (master) and a memory responder (slave).
interface llc_mem_if #(
    parameter int unsigned LINE_ADDR_W = 28,
    parameter int unsigned LINE_W      = 128,
    parameter int unsigned HSIZE_W     = 3,
    parameter int unsigned HPROT_W     = 2
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_hwrite;
    logic [HSIZE_W-1:0]     req_hsize;
    logic [HPROT_W-1:0]     req_hprot;
    logic [LINE_ADDR_W-1:0] req_addr;
    logic [LINE_W-1:0]      req_line;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [LINE_W-1:0]      rsp_line;

    modport master (
        output req_valid, req_hwrite, req_hsize, req_hprot, req_addr, req_line, rsp_ready,
        input  req_ready, rsp_valid, rsp_line
    );

    modport slave (
        input  req_valid, req_hwrite, req_hsize, req_hprot, req_addr, req_line, rsp_ready,
        output req_ready, rsp_valid, rsp_line
    );
endinterface

// File: rtl/llc_mem_responder.sv
// Line-wide memory model behind the LLC: zero sweep on reset, fixed-latency in-order reads, credit backpressure.
// Optional MEM_OOR_CHECK_EN: flags/drops out-of-range requests and adds the sticky err_oor output.
module llc_mem_responder #(
    parameter int unsigned LINE_ADDR_W = 28,
    parameter int unsigned LINE_W      = 128,
    parameter int unsigned MEM_LINES   = 256,
    parameter int unsigned RD_LATENCY  = 4,
    parameter int unsigned RSP_DEPTH   = 4
) (
    input  logic     clk,
    input  logic     rst,
    llc_mem_if.slave bus,
    output logic     init_done
`ifdef MEM_OOR_CHECK_EN
   ,output logic     err_oor
`endif
);
    localparam int unsigned IDX_W = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      init_idx_q, init_idx_d;
    logic [CNT_W-1:0]      credit_q, credit_d;
    logic                  req_ready_q, req_ready_d;
    logic                  init_done_q, init_done_d;
    logic [RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [LINE_W-1:0]     pipe_data_q [RD_LATENCY];
    logic [LINE_W-1:0]     pipe_data_d [RD_LATENCY];
    logic [LINE_W-1:0]     fifo_q [RSP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [LINE_W-1:0]     rsp_line_q, rsp_line_d;
    logic [LINE_W-1:0]     mem_q [MEM_LINES];

    logic                  mem_we_c;
    logic [IDX_W-1:0]      mem_waddr_c;
    logic [LINE_W-1:0]     mem_wdata_c;
    logic [IDX_W-1:0]      req_idx_c;
    logic                  accept_c, rd_acc_c, push_c, pop_c, oor_c;
    logic                  unused_c;

    assign req_idx_c = bus.req_addr[IDX_W-1:0];
    assign accept_c  = bus.req_valid && req_ready_q;
    assign rd_acc_c  = accept_c && !bus.req_hwrite;
    assign push_c    = pipe_vld_q[RD_LATENCY-1];
    assign pop_c     = rsp_valid_q && bus.rsp_ready;
    assign unused_c  = ^{bus.req_hsize, bus.req_hprot, bus.req_addr};

`ifdef MEM_OOR_CHECK_EN
    logic err_oor_q, err_oor_d;
    assign oor_c     = (bus.req_addr >= LINE_ADDR_W'(MEM_LINES));
    assign err_oor_d = err_oor_q || (accept_c && oor_c);
    assign err_oor   = err_oor_q;
    always_ff @(posedge clk) begin
        if (rst) err_oor_q <= 1'b0;
        else     err_oor_q <= err_oor_d;
    end
`else
    assign oor_c = 1'b0;
`endif

    // Zero sweep, array write port and credit accounting.
    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        mem_we_c    = 1'b0;
        mem_waddr_c = req_idx_c;
        mem_wdata_c = bus.req_line;
        case (state_q)
            ST_INIT: begin
                mem_we_c    = 1'b1;
                mem_waddr_c = init_idx_q;
                mem_wdata_c = '0;
                init_idx_d  = init_idx_q + IDX_W'(1);
                if (init_idx_q == IDX_W'(MEM_LINES - 1)) state_d = ST_RUN;
            end
            default: mem_we_c = accept_c && bus.req_hwrite && !oor_c;
        endcase
        credit_d    = credit_q + CNT_W'(rd_acc_c) - CNT_W'(pop_c);
        req_ready_d = (state_d == ST_RUN) && (credit_d < CNT_W'(RSP_DEPTH));
        init_done_d = (state_d == ST_RUN);
    end

    // Stage 0 samples the array at acceptance; out-of-range reads carry a zero line.
    always_comb begin
        pipe_vld_d     = '0;
        pipe_vld_d[0]  = rd_acc_c;
        pipe_data_d[0] = oor_c ? '0 : mem_q[req_idx_c];
        for (int i = 1; i < int'(RD_LATENCY); i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_data_d[i] = pipe_data_q[i-1];
        end
    end

    // Response FIFO; the output register shows the next head, bypassing a same-cycle push into it.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_c) wr_ptr_d = (wr_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        if (pop_c)  rd_ptr_d = (rd_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        fifo_cnt_d  = fifo_cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
        rsp_valid_d = (fifo_cnt_d != '0);
        rsp_line_d  = '0;
        if (push_c && (rd_ptr_d == wr_ptr_q)) rsp_line_d = pipe_data_q[RD_LATENCY-1];
        else if (rsp_valid_d)                 rsp_line_d = fifo_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_idx_q  <= '0;
            credit_q    <= '0;
            req_ready_q <= 1'b0;
            init_done_q <= 1'b0;
            pipe_vld_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_line_q  <= '0;
        end else begin
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            credit_q    <= credit_d;
            req_ready_q <= req_ready_d;
            init_done_q <= init_done_d;
            pipe_vld_q  <= pipe_vld_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_line_q  <= rsp_line_d;
        end
    end

    // Data storage needs no reset: valid bits and the sweep cover it.
    always_ff @(posedge clk) begin
        if (mem_we_c) mem_q[mem_waddr_c] <= mem_wdata_c;
        if (push_c)   fifo_q[wr_ptr_q]   <= pipe_data_q[RD_LATENCY-1];
        pipe_data_q <= pipe_data_d;
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_line  = rsp_line_q;
    assign init_done     = init_done_q;
endmodule
